tff_bank_sync: RTL

- Parametrised bank of WIDTH toggle flip-flops with a shared mode control: hold, per-bit toggle, parallel load, and chained-toggle count.
- In count mode the T-FFs are chained into an up/down binary counter.
- Successor to the single-bit T flip-flop in the sequential-logic FF set. Adds width, synchronous reset, load, count chaining, a wrap flag and change reporting.

---
 rtl/tff_bank_sync.sv | 113 +++++++++++
 1 files changed

// File: rtl/tff_bank_sync.sv
// tff_bank_sync
// Bank of WIDTH toggle flip-flops sharing one mode control. Each edge the bank
// holds, toggles under a per-bit mask, parallel-loads, or counts up/down.
// In count mode the flip-flops are chained through explicit toggle enables.
// Bit i toggles when all lower bits are 1 (up) or all lower bits are 0 (down).
// Also reports a wrap pulse and the set of bits that changed on the last edge.
//
// Optional build macro: TFF_BANK_SAT_EN
//   defined   -> count mode saturates at the limit instead of wrapping.
//                wrap is asserted on every blocked count step.
//   undefined -> count mode wraps modulo 2^WIDTH.
//                wrap is a single pulse per crossing.
//
// Port handshake: there is none. Inputs are sampled on every rising edge.
// All outputs are registered and describe the result of the previous edge.

module tff_bank_sync #(
   parameter int unsigned           WIDTH   = 8,
   parameter logic [WIDTH-1:0]      RST_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] t,
   input  logic             up,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             wrap,
   output logic [WIDTH-1:0] toggled
);

   localparam logic [1:0] MODE_HOLD   = 2'b00;
   localparam logic [1:0] MODE_TOGGLE = 2'b01;
   localparam logic [1:0] MODE_LOAD   = 2'b10;
   localparam logic [1:0] MODE_COUNT  = 2'b11;

   logic [WIDTH-1:0] r_q;
   logic             r_wrap;
   logic [WIDTH-1:0] r_toggled;

   logic [WIDTH-1:0] w_en_up;     // bit i toggles when counting up
   logic [WIDTH-1:0] w_en_dn;     // bit i toggles when counting down
   logic [WIDTH-1:0] w_cnt_mask;
   logic             w_at_limit;  // step would cross all-ones (up) or zero (down)
   logic [WIDTH-1:0] w_q_next;
   logic             w_wrap_next;

   // Ripple of per-bit toggle enables: each stage qualifies the one above it.
   assign w_en_up[0] = 1'b1;
   assign w_en_dn[0] = 1'b1;
   for (genvar i = 1; i < WIDTH; i++) begin : g_chain
      assign w_en_up[i] = w_en_up[i-1] &  r_q[i-1];
      assign w_en_dn[i] = w_en_dn[i-1] & ~r_q[i-1];
   end

   assign w_cnt_mask = up ? w_en_up : w_en_dn;

   // The top stage's enable combined with the top bit is the terminal detect.
   assign w_at_limit = up ? (w_en_up[WIDTH-1] &  r_q[WIDTH-1])
                          : (w_en_dn[WIDTH-1] & ~r_q[WIDTH-1]);

   // Next-state selection for the bank and wrap flag from the current mode.
   always_comb begin
      w_q_next    = r_q;
      w_wrap_next = 1'b0;
      case (mode)
         MODE_HOLD: begin
            w_q_next = r_q;
         end
         MODE_TOGGLE: begin
            w_q_next = r_q ^ t;
         end
         MODE_LOAD: begin
            w_q_next = d;
         end
         MODE_COUNT: begin
            // Only t[0] enables counting; the upper mask bits are ignored.
            if (t[0]) begin
               w_wrap_next = w_at_limit;
`ifdef TFF_BANK_SAT_EN
               // A blocked step at the limit leaves q untouched.
               if (!w_at_limit) begin
                  w_q_next = r_q ^ w_cnt_mask;
               end
`else
               w_q_next = r_q ^ w_cnt_mask;
`endif
            end
         end
         default: begin
            w_q_next = r_q;
         end
      endcase
   end

   // State register: reset overrides every mode and suppresses wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q       <= RST_VAL;
         r_wrap    <= 1'b0;
         r_toggled <= '0;
      end else begin
         r_q       <= w_q_next;
         r_wrap    <= w_wrap_next;
         r_toggled <= w_q_next ^ r_q;
      end
   end

   assign q       = r_q;
   assign wrap    = r_wrap;
   assign toggled = r_toggled;

endmodule
